// File: rtl/rgb_row_stream_pkg.sv
// System definitions for the YCbCr row streamer: sample width, block/row
// types, colour-conversion coefficients and the 8-bit clamp helper.
package rgb_row_stream_pkg;

    localparam int Q = 12;
    // Intermediate width for products and sums in the colour conversion.
    localparam int W = Q + 10;

    localparam int signed C_RV = 359;
    localparam int signed C_GU = 88;
    localparam int signed C_GV = 183;
    localparam int signed C_BU = 454;

    typedef logic signed [Q-1:0] sample_t;
    // Indexed [row][col].
    typedef sample_t [7:0][7:0] block_t;
    // One pixel row, indexed [col].
    typedef logic [7:0][7:0] row_t;

    function automatic logic [7:0] clamp8(input logic signed [W-1:0] v);
        if (v < 0)
            return '0;
        else if (v > 255)
            return '1;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/rgb_row_stream_if.sv
// Block-triplet input and pixel-row output handshake bundle.
interface rgb_row_stream_if;
    import rgb_row_stream_pkg::*;

    block_t       y_in;
    block_t       cb_in;
    block_t       cr_in;
    logic         valid_in;
    logic         out_ready;
    row_t         r_out;
    row_t         g_out;
    row_t         b_out;
    logic [2:0]   row_idx;
    logic         out_valid;
    logic         last_row;

    modport master (
        output y_in, cb_in, cr_in, valid_in, out_ready,
        input  r_out, g_out, b_out, row_idx, out_valid, last_row
    );

    modport slave (
        input  y_in, cb_in, cr_in, valid_in, out_ready,
        output r_out, g_out, b_out, row_idx, out_valid, last_row
    );

endinterface

// File: rtl/rgb_row_stream_ycc_pixel.sv
// Single-pixel YCbCr -> RGB conversion with saturation to 0..255.
module ycc_pixel
    import rgb_row_stream_pkg::*;
(
    input  sample_t    y,
    input  sample_t    cb,
    input  sample_t    cr,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    logic signed [W-1:0] yw, cbw, crw;
    logic signed [W-1:0] r_off, g_off, b_off;
    logic signed [W-1:0] r_sum, g_sum, b_sum;

    assign yw  = W'(y);
    assign cbw = W'(cb);
    assign crw = W'(cr);

    // Rounded, floor-shifted chroma contributions.
    assign r_off = W'((C_RV * crw + 128) >>> 8);
    assign g_off = W'((C_GU * cbw + C_GV * crw + 128) >>> 8);
    assign b_off = W'((C_BU * cbw + 128) >>> 8);

    assign r_sum = yw + W'(128) + r_off;
    assign g_sum = yw + W'(128) - g_off;
    assign b_sum = yw + W'(128) + b_off;

    assign r = clamp8(r_sum);
    assign g = clamp8(g_sum);
    assign b = clamp8(b_sum);

endmodule

// File: rtl/rgb_row_stream.sv
// Buffers DEPTH YCbCr 8x8 block triplets and streams them out as converted
// RGB pixel rows, one row per cycle, through a single output register.
module rgb_row_stream
    import rgb_row_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    rgb_row_stream_if.slave  bus,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    block_t y_mem  [DEPTH];
    block_t cb_mem [DEPTH];
    block_t cr_mem [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [2:0]    head_row;

    logic load, release_head, full_c, wr_en, drop;

    sample_t [7:0] head_y, head_cb, head_cr;
    row_t          conv_r, conv_g, conv_b;

    always_comb begin
        full_c       = (count == CW'(DEPTH));
        load         = (count != '0) && (!bus.out_valid || bus.out_ready);
        release_head = load && (head_row == 3'd7);
        // A full buffer still accepts when the head slot frees on this edge.
        wr_en        = bus.valid_in && (!full_c || release_head);
        drop         = bus.valid_in && full_c && !release_head;
    end

    assign full = full_c;

    assign head_y  = y_mem[rd_ptr][head_row];
    assign head_cb = cb_mem[rd_ptr][head_row];
    assign head_cr = cr_mem[rd_ptr][head_row];

    for (genvar c = 0; c < 8; c++) begin : g_px
        ycc_pixel u_px (
            .y  (head_y[c]),
            .cb (head_cb[c]),
            .cr (head_cr[c]),
            .r  (conv_r[c]),
            .g  (conv_g[c]),
            .b  (conv_b[c])
        );
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            y_mem[wr_ptr]  <= bus.y_in;
            cb_mem[wr_ptr] <= bus.cb_in;
            cr_mem[wr_ptr] <= bus.cr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            head_row      <= '0;
            overflow      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.row_idx   <= '0;
            bus.last_row  <= 1'b0;
            bus.r_out     <= '0;
            bus.g_out     <= '0;
            bus.b_out     <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (release_head)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(release_head);
            if (drop)
                overflow <= 1'b1;

            if (load) begin
                bus.r_out     <= conv_r;
                bus.g_out     <= conv_g;
                bus.b_out     <= conv_b;
                bus.row_idx   <= head_row;
                bus.last_row  <= (head_row == 3'd7);
                bus.out_valid <= 1'b1;
                head_row      <= head_row + 3'd1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb_row_stream.sv
// Directed scoreboard bench for rgb_row_stream.
module tb_rgb_row_stream;
    import rgb_row_stream_pkg::*;

    typedef struct {
        row_t       r;
        row_t       g;
        row_t       b;
        logic [2:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic full, overflow;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    rgb_row_stream_if bus ();

    rgb_row_stream #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int fdiv256(input int n);
        if (n >= 0) return n / 256;
        return -((-n + 255) / 256);
    endfunction

    function automatic int clip(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic block_t mk(input int seed, input int comp);
        block_t blk;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = sample_t'(((seed * 97 + comp * 31 + r * 13 + c * 7) % 512) - 256);
        return blk;
    endfunction

    function automatic block_t fill(input int v);
        block_t blk;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = sample_t'(v);
        return blk;
    endfunction

    task automatic push_model(input block_t yb, input block_t cbb, input block_t crb);
        exp_t    e;
        sample_t s;
        int      yi, cbi, cri, yp;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                s = yb[r][c];  yi  = s;
                s = cbb[r][c]; cbi = s;
                s = crb[r][c]; cri = s;
                yp = yi + 128;
                e.r[c] = 8'(clip(yp + fdiv256(359 * cri + 128)));
                e.g[c] = 8'(clip(yp - fdiv256(88 * cbi + 183 * cri + 128)));
                e.b[c] = 8'(clip(yp + fdiv256(454 * cbi + 128)));
            end
            e.idx = 3'(r);
            sb.push_back(e);
        end
    endtask

    task automatic push_const(input int rv, input int gv, input int bv);
        exp_t e;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                e.r[c] = 8'(rv);
                e.g[c] = 8'(gv);
                e.b[c] = 8'(bv);
            end
            e.idx = 3'(r);
            sb.push_back(e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input block_t yb, input block_t cbb, input block_t crb, input bit model);
        bus.y_in     = yb;
        bus.cb_in    = cbb;
        bus.cr_in    = crb;
        bus.valid_in = 1'b1;
        if (model) push_model(yb, cbb, crb);
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
        tick();
    endtask

    task automatic wait_row(input logic [2:0] idx, input int budget);
        for (int i = 0; i < budget && !(bus.out_valid && bus.row_idx == idx); i++) tick();
        check("wait_row", {63'd0, bus.out_valid && bus.row_idx == idx}, 64'd1);
    endtask

    // Scoreboard monitor: a row transfers on the edge after this sample.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            tests++;
            assert (sb.size() != 0)
            else begin
                fails++;
                $error("FAIL unexpected_row observed=row%0d expected=none", bus.row_idx);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("row_r", bus.r_out, e.r);
                check("row_g", bus.g_out, e.g);
                check("row_b", bus.b_out, e.b);
                check("row_idx", 64'(bus.row_idx), 64'(e.idx));
                check("last_row", 64'(bus.last_row), 64'(e.idx == 3'd7));
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.valid_in  = 1'b0;
        bus.out_ready = 1'b0;
        bus.y_in      = '0;
        bus.cb_in     = '0;
        bus.cr_in     = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_row_idx", 64'(bus.row_idx), 64'd0);
        check("rst_last_row", 64'(bus.last_row), 64'd0);
        check("rst_r_out", bus.r_out, 64'd0);

        // Zero block: mid-grey everywhere, two-cycle latency.
        bus.out_ready = 1'b1;
        push_const(128, 128, 128);
        send(fill(0), fill(0), fill(0), 1'b0);
        check("lat_t1_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_t2_valid", 64'(bus.out_valid), 64'd1);
        check("lat_t2_row", 64'(bus.row_idx), 64'd0);
        drain(20);
        check("idle_valid", 64'(bus.out_valid), 64'd0);

        // Saturation cases.
        push_const(255, 164, 255);
        send(fill(127), fill(0), fill(127), 1'b0);
        drain(20);
        push_const(0, 44, 0);
        send(fill(-128), fill(-128), fill(0), 1'b0);
        drain(20);

        // Four blocks into a stalled consumer.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(mk(k, 0), mk(k, 1), mk(k, 2), 1'b1);
        check("stall_full", 64'(full), 64'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_row", 64'(bus.row_idx), 64'd0);
            check("stall_r", bus.r_out, sb[0].r);
        end
        bus.out_ready = 1'b1;
        drain(60);
        check("stall_overflow", 64'(overflow), 64'd0);
        check("stall_full_after", 64'(full), 64'd0);

        // Write accepted on the edge that frees the head slot.
        bus.out_ready = 1'b0;
        for (int k = 4; k < 8; k++) send(mk(k, 0), mk(k, 1), mk(k, 2), 1'b1);
        bus.out_ready = 1'b1;
        tick();
        wait_row(3'd6, 20);
        send(mk(8, 0), mk(8, 1), mk(8, 2), 1'b1);
        check("rel_overflow", 64'(overflow), 64'd0);
        check("rel_full", 64'(full), 64'd1);
        drain(60);

        // Write dropped while full with no release.
        bus.out_ready = 1'b0;
        for (int k = 9; k < 13; k++) send(mk(k, 0), mk(k, 1), mk(k, 2), 1'b1);
        send(mk(13, 0), mk(13, 1), mk(13, 2), 1'b0);
        check("drop_overflow", 64'(overflow), 64'd1);
        check("drop_full", 64'(full), 64'd1);
        bus.out_ready = 1'b1;
        drain(60);
        check("drop_sticky", 64'(overflow), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("drop_cleared", 64'(overflow), 64'd0);

        // Reset mid-block discards everything; valid_in during reset ignored.
        send(mk(20, 0), mk(20, 1), mk(20, 2), 1'b1);
        wait_row(3'd3, 20);
        rst          = 1'b1;
        bus.y_in     = mk(21, 0);
        bus.valid_in = 1'b1;
        tick();
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        sb.delete();
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_full", 64'(full), 64'd0);
        tick();
        tick();
        check("mid_rst_ignored", 64'(bus.out_valid), 64'd0);
        send(mk(22, 0), mk(22, 1), mk(22, 2), 1'b1);
        tick();
        check("restart_valid", 64'(bus.out_valid), 64'd1);
        check("restart_row", 64'(bus.row_idx), 64'd0);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rgb_row_stream.md
RGB_ROW_STREAM -- requirements
Module: rgb_row_stream

Interface
REQ-001 Parameter DEPTH, default 4: number of 8x8 block triplets the block buffers.
REQ-002 clk  input  1  clock; all state changes on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 y_in  input  [`Q-1:0] x [7:0][7:0]  Y block, signed two's complement, level-shifted (centred on 0).
REQ-005 cb_in  input  [`Q-1:0] x [7:0][7:0]  Cb block, signed, same alignment as y_in.
REQ-006 cr_in  input  [`Q-1:0] x [7:0][7:0]  Cr block, signed, same alignment as y_in.
REQ-007 valid_in  input  1  y/cb/cr_in hold one co-sited block triplet this cycle; no backpressure upstream.
REQ-008 out_ready  input  1  consumer accepts the presented row this cycle.
REQ-009 r_out, g_out, b_out  output  [7:0] x [7:0] each  one pixel row, unsigned 8-bit per pixel, index = column.
REQ-010 row_idx  output  3  row number (0..7) of the presented row.
REQ-011 out_valid  output  1  r/g/b_out, row_idx, last_row are valid.
REQ-012 last_row  output  1  presented row is row 7 of its block.
REQ-013 full  output  1  buffer holds DEPTH triplets.
REQ-014 overflow  output  1  sticky; a triplet was dropped.

Function
REQ-015 Buffer is a circular FIFO of DEPTH triplets; wr_ptr, rd_ptr wrap modulo DEPTH; count 0..DEPTH.
REQ-016 valid_in with count<DEPTH writes the triplet at wr_ptr on the same edge; wr_ptr and count increment.
REQ-017 valid_in with count==DEPTH and no same-cycle head release: triplet dropped, overflow set, held until rst.
REQ-018 Head release (row 7 of head transferred) in the same cycle as valid_in at count==DEPTH: write accepted, count unchanged, no overflow.
REQ-019 Internal row counter selects the head row; it increments on each row load into the output register; at 7 it wraps to 0 and frees the head slot (rd_ptr+1, count-1).
REQ-020 Output register loads a converted row when count>0 and (out_valid==0 or out_ready==1); otherwise it holds all outputs stable.
REQ-021 out_valid deasserts when the register is consumed and no row is available to load.
REQ-022 Latency: valid_in in cycle t into an empty block -> row 0 presented with out_valid in cycle t+2; throughput 1 row/cycle, 8 cycles/block with out_ready high.
REQ-023 Per pixel: Yp = Y+128; R = Yp + ((359*Cr + 128) >>> 8); G = Yp - ((88*Cb + 183*Cr + 128) >>> 8); B = Yp + ((454*Cb + 128) >>> 8).
REQ-024 Intermediates are signed, wide enough for `Q+10 bits without overflow; >>> is arithmetic (floor).
REQ-025 Each of R, G, B is clamped: <0 -> 0, >255 -> 255.
REQ-026 Rows leave in order: block FIFO order, rows 0..7 within a block, no gaps or repeats.
REQ-027 full = (count==DEPTH), combinational from state.

Reset
REQ-028 On rst: count, wr_ptr, rd_ptr, row counter = 0; out_valid=0, overflow=0, row_idx=0, last_row=0, r/g/b_out=0.
REQ-029 rst mid-block discards all buffered triplets and the in-flight row; valid_in during rst is ignored.
REQ-030 Buffer storage contents need no reset.

Structure
REQ-031 `Q, the BLOCK typedef and the coefficients 359/88/183/454 live in sys_defs.
REQ-032 One sub-module, ycc_pixel: single-pixel combinational convert-and-clamp, instantiated 8 times per row.

Verification
REQ-033 Y=Cb=Cr=0 block, out_ready=1 -> 8 rows, all pixels R=G=B=128, out_valid cycles t+2..t+9, last_row on row 7 only.
REQ-034 Y=127, Cb=0, Cr=127 -> R=255 (clamped), G=164, B=255 in every pixel.
REQ-035 Y=-128, Cb=-128, Cr=0 -> R=0, G=44, B=0 (clamped).
REQ-036 Four triplets on consecutive cycles, out_ready held low 10 cycles then high -> full=1, outputs frozen while stalled, 32 rows in order, overflow=0.
REQ-037 Fifth triplet while full with out_ready=0 -> dropped, overflow=1 until rst; same at row-7 transfer -> accepted, overflow=0.
REQ-038 rst asserted mid-block (row 3) -> next cycle out_valid=0, count=0; a new triplet restarts at row 0.
